gate_mux_checker: RTL
=====================

# gate_mux_checker

Self-checking stimulus sequencer that sits directly upstream of the mux-based gate block (AND/OR/NOT built from 2:1 muxes) and also consumes its outputs. On a start pulse it drives all four (a, b) input combinations in order and waits a programmable settle time after each. It then compares the gate block's outputs against golden values and reports a pass/fail verdict with a mismatch count. It replaces hand-written time-delayed stimulus with a clocked, repeatable sweep usable in simulation and on-board.

## Interface
Parameters:
- SETTLE_CYCLES, 1: cycles held per vector before sampling; legal range 1..255.
- ERR_W, 4: width of err_count; minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- a  out  1  drive to gate block input a.
- b  out  1  drive to gate block input b.
- and_in  in  1  gate block AND output.
- or_in  in  1  gate block OR output.
- not_in  in  1  gate block NOT(a) output.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next accepted start or reset.
- pass  out  1  high with done when err_count == 0.
- err_count  out  ERR_W  number of mismatching vectors, saturating.
- fail_vec  out  2  {a,b} of the first failing vector. Present only with CAPTURE_EN.
- fail_obs  out  3  {and,or,not} observed at the first failure. Present only with CAPTURE_EN.

## Operation
- The FSM has four states: IDLE, WAIT, CHECK and DONE.
- IDLE or DONE, with start=1:
  - vec←0, {a,b}←2'b00, settle counter←SETTLE_CYCLES.
  - err_count←0; capture registers and their valid flag are cleared.
  - done←0, pass←0, busy←1, next state WAIT.
- WAIT: the counter decrements every cycle. When it reaches 1, the next state is CHECK.
- CHECK compares and_in, or_in and not_in against the golden values a&b, a|b and ~a.
  - Any bit mismatch counts the vector once. err_count increments and saturates at 2^ERR_W−1.
  - If vec==3: next state DONE, busy←0, done←1, pass←(final err_count==0).
  - Otherwise: vec←vec+1, {a,b}←vec+1, counter reloads, next state WAIT.
- Vector order is {a,b} = 00, 01, 10, 11.
- start while busy is ignored and has no effect on the sweep.
- DONE holds all outputs, including the last vector on a and b, until the next start or reset.

## Timing
- The start edge counts as cycle 0. Vector n is driven from cycle n·(SETTLE_CYCLES+1) onward.
- The sample for vector n is taken at the edge ending cycle n·(SETTLE_CYCLES+1)+SETTLE_CYCLES.
- done, pass and the final err_count are visible from cycle 4·(SETTLE_CYCLES+1). With the default, that is cycle 8.
- The gate block is combinational. All SETTLE_CYCLES ≥ 1 must yield identical verdicts.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_obs=0, state IDLE.
- Reset asserted mid-sweep returns every output to its reset value on the next edge. No partial result is retained.
- start and rst high together: rst wins.
- A restart from DONE is accepted on the same edge that start is sampled. done drops at that edge.

## Configuration
- Macro: GATE_MUX_CHECKER_CAPTURE_EN.
- Defined:
  - fail_vec and fail_obs ports exist.
  - At the first mismatching CHECK of a sweep, they load {a,b} and {and_in,or_in,not_in} and set an internal valid flag.
  - Later mismatches do not overwrite them. They clear on an accepted start or on reset.
- Undefined: the ports and capture registers are absent; all other behaviour is identical.

## Test plan
- Correct gate block, SETTLE_CYCLES=1, start pulse at cycle 0 → a/b step 00, 01, 10, 11 every 2 cycles. At cycle 8: done=1, busy=0, pass=1, err_count=0.
- AND output forced to 0 → only vector 11 fails. Result: err_count=1, pass=0, fail_vec=2'b11, fail_obs=3'b010.
- NOT output wired to a (not inverted), ERR_W=2 → all 4 vectors fail and err_count saturates at 3. Result: pass=0, fail_vec=2'b00, fail_obs=3'b000.
- Extra start pulse at cycle 3 of a sweep → ignored; done still asserts at cycle 8 with an unchanged vector order.
- rst asserted at cycle 5 of a sweep → next edge: busy=0, done=0, a=b=0, err_count=0. A fresh start then completes normally.
- From DONE with err_count=1, pulse start against a correct block → err_count clears on the start edge. Sweep ends with pass=1 and, if capture is enabled, fail_vec=0.

Source files
------------

// File: rtl/gate_mux_checker.sv
// Sweeps {a,b} through 00..11 into the mux gate block, checks AND/OR/NOT against golden values.
// Define GATE_MUX_CHECKER_CAPTURE_EN to add first-failure capture ports (o_fail_vec, o_fail_obs).
module gate_mux_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_a,
    output logic             o_b,
    input  logic             i_and_in,
    input  logic             i_or_in,
    input  logic             i_not_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count
`ifdef GATE_MUX_CHECKER_CAPTURE_EN
    ,
    output logic [1:0]       o_fail_vec,
    output logic [2:0]       o_fail_obs
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]       SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [7:0]       r_cnt;
    logic [ERR_W-1:0] r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    state_t           w_state_nxt;
    logic [1:0]       w_vec_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [2:0]       w_golden;
    logic [2:0]       w_obs;
    logic             w_mismatch;
    logic             w_accept;

    assign w_golden   = {r_vec[1] & r_vec[0], r_vec[1] | r_vec[0], ~r_vec[1]};
    assign w_obs      = {i_and_in, i_or_in, i_not_in};
    assign w_mismatch = (w_obs != w_golden);
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_vec_nxt   = 2'b00;
                    w_cnt_nxt   = SETTLE;
                    w_err_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // A vector counts once however many outputs disagree.
                if (w_mismatch && (r_err != ERR_MAX)) begin
                    w_err_nxt = r_err + 1'b1;
                end
                if (r_vec == 2'b11) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                    w_state_nxt = S_DONE;
                end else begin
                    w_vec_nxt   = r_vec + 2'b01;
                    w_cnt_nxt   = SETTLE;
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_vec   <= 2'b00;
            r_cnt   <= 8'd0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign o_a         = r_vec[1];
    assign o_b         = r_vec[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;

`ifdef GATE_MUX_CHECKER_CAPTURE_EN
    logic       r_cap_valid;
    logic [1:0] r_fail_vec;
    logic [2:0] r_fail_obs;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_cap_valid <= 1'b0;
            r_fail_vec  <= 2'b00;
            r_fail_obs  <= 3'b000;
        end else if ((r_state == S_CHECK) && w_mismatch && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_fail_vec  <= r_vec;
            r_fail_obs  <= w_obs;
        end
    end

    assign o_fail_vec = r_fail_vec;
    assign o_fail_obs = r_fail_obs;
`endif

endmodule
